rca_cfg_readback: RTL and testbench

RCA_CFG_READBACK -- requirements
Module: rca_cfg_readback

---
 rtl/rca_config_pkg.sv | 19 +
 rtl/rca_cfg_readback.sv | 124 ++++++++++++
 tb/tb_rca_cfg_readback.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rca_config_pkg.sv
// Shared RCA configuration definitions: readback FSM states and entry-count helpers.
package rca_config;

  typedef enum logic [1:0] {
    RB_IDLE,
    RB_FETCH,
    RB_CAPTURE,
    RB_STREAM
  } rca_cfg_rb_state_t;

  localparam int unsigned RB_ADDR_W = 5;

  function automatic int unsigned rb_entry_count(input int unsigned nr, input int unsigned nw);
    return nr + nw;
  endfunction

  localparam int unsigned RB_NUM_ENTRIES = rb_entry_count(5, 2);

endpackage

// File: rtl/rca_cfg_readback.sv
// Reads one RCA's source/destination register map from the config store and
// streams it out one entry per handshake: sources first, then destinations.
module rca_cfg_readback
  import rca_config::*;
#(
  parameter int unsigned NUM_RCAS        = 4,
  parameter int unsigned NUM_READ_PORTS  = 5,
  parameter int unsigned NUM_WRITE_PORTS = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req_valid,
  input  logic [$clog2(NUM_RCAS)-1:0]            req_rca_sel,
  output logic                                   req_ready,
  output logic                                   cfg_rd_en,
  output logic [$clog2(NUM_RCAS)-1:0]            cfg_rd_rca,
  input  logic [RB_ADDR_W*NUM_READ_PORTS-1:0]    cfg_rd_src,
  input  logic [RB_ADDR_W*NUM_WRITE_PORTS-1:0]   cfg_rd_dest,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [RB_ADDR_W-1:0]                   out_reg_addr,
  output logic                                   out_is_dest,
  output logic [$clog2((NUM_READ_PORTS > NUM_WRITE_PORTS) ? NUM_READ_PORTS : NUM_WRITE_PORTS)-1:0] out_port_idx,
  output logic                                   out_last,
  input  logic                                   flush
);

  localparam int unsigned NUM_ENTRIES = rb_entry_count(NUM_READ_PORTS, NUM_WRITE_PORTS);
  localparam int unsigned SEL_W       = $clog2(NUM_RCAS);
  localparam int unsigned MAX_PORTS   = (NUM_READ_PORTS > NUM_WRITE_PORTS) ? NUM_READ_PORTS : NUM_WRITE_PORTS;
  localparam int unsigned PIDX_W      = $clog2(MAX_PORTS);
  localparam int unsigned CNT_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int unsigned SRC_W       = RB_ADDR_W * NUM_READ_PORTS;
  localparam int unsigned DEST_W      = RB_ADDR_W * NUM_WRITE_PORTS;

  rca_cfg_rb_state_t  state_q, state_d;
  logic [SEL_W-1:0]   rca_q, rca_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [DEST_W-1:0]  dest_q, dest_d;

  logic stream;
  logic at_last;
  logic handshake;

  assign stream    = (state_q == RB_STREAM);
  assign at_last   = (cnt_q == CNT_W'(NUM_ENTRIES - 1));
  assign handshake = stream && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RB_IDLE;
      rca_q   <= '0;
      cnt_q   <= '0;
      src_q   <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      rca_q   <= rca_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dest_q  <= dest_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rca_d   = rca_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dest_d  = dest_q;
    unique case (state_q)
      RB_IDLE: begin
        if (req_valid && !flush) begin
          rca_d   = req_rca_sel;
          state_d = RB_FETCH;
        end
      end
      RB_FETCH: state_d = RB_CAPTURE;
      RB_CAPTURE: begin
        src_d   = cfg_rd_src;
        dest_d  = cfg_rd_dest;
        cnt_d   = '0;
        state_d = RB_STREAM;
      end
      RB_STREAM: begin
        // Counter parks on the last entry; leaving STREAM ends the readback.
        if (handshake) begin
          if (at_last) state_d = RB_IDLE;
          else         cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RB_IDLE;
    endcase
    if (flush) state_d = RB_IDLE;
  end

  always_comb begin
    req_ready    = (state_q == RB_IDLE) && !flush;
    cfg_rd_en    = (state_q == RB_FETCH);
    cfg_rd_rca   = (state_q == RB_FETCH) ? rca_q : '0;
    out_valid    = stream;
    out_reg_addr = '0;
    out_is_dest  = 1'b0;
    out_port_idx = '0;
    out_last     = stream && at_last;
    if (stream) begin
      for (int unsigned i = 0; i < NUM_READ_PORTS; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          out_reg_addr = src_q[RB_ADDR_W*i +: RB_ADDR_W];
          out_port_idx = PIDX_W'(i);
        end
      end
      for (int unsigned i = 0; i < NUM_WRITE_PORTS; i++) begin
        if (cnt_q == CNT_W'(NUM_READ_PORTS + i)) begin
          out_reg_addr = dest_q[RB_ADDR_W*i +: RB_ADDR_W];
          out_is_dest  = 1'b1;
          out_port_idx = PIDX_W'(i);
        end
      end
    end
  end

endmodule

// File: tb/tb_rca_cfg_readback.sv
// Scoreboard bench for rca_cfg_readback: stimulus pushes expected entries,
// a negedge monitor compares every presented entry and pops on handshake.
module tb_rca_cfg_readback;

  localparam int NR     = 5;
  localparam int NW     = 2;
  localparam int NE     = NR + NW;
  localparam int SRC_W  = 5 * NR;
  localparam int DEST_W = 5 * NW;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic [1:0]        req_rca_sel;
  logic              req_ready;
  logic              cfg_rd_en;
  logic [1:0]        cfg_rd_rca;
  logic [SRC_W-1:0]  cfg_rd_src;
  logic [DEST_W-1:0] cfg_rd_dest;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_reg_addr;
  logic              out_is_dest;
  logic [2:0]        out_port_idx;
  logic              out_last;
  logic              flush;

  rca_cfg_readback #(
    .NUM_RCAS       (4),
    .NUM_READ_PORTS (NR),
    .NUM_WRITE_PORTS(NW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_rca_sel (req_rca_sel),
    .req_ready   (req_ready),
    .cfg_rd_en   (cfg_rd_en),
    .cfg_rd_rca  (cfg_rd_rca),
    .cfg_rd_src  (cfg_rd_src),
    .cfg_rd_dest (cfg_rd_dest),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_reg_addr(out_reg_addr),
    .out_is_dest (out_is_dest),
    .out_port_idx(out_port_idx),
    .out_last    (out_last),
    .flush       (flush)
  );

  typedef struct {
    logic [4:0] addr;
    bit         is_dest;
    int         idx;
    bit         last;
  } exp_t;

  exp_t        exp_q[$];
  logic [4:0]  mem_src [4][NR];
  logic [4:0]  mem_dest[4][NW];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          pop_cnt = 0;
  int          accepts = 0;
  int          pulses = 0;
  int unsigned resp_rca;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Config store model: answers a read strobe one cycle later, then scrambles.
  initial begin
    cfg_rd_src  = '0;
    cfg_rd_dest = '0;
    forever begin
      @(negedge clk);
      if (cfg_rd_en && !rst) begin
        resp_rca = int'(cfg_rd_rca);
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) cfg_rd_src[5*i +: 5] = mem_src[resp_rca][i];
        for (int i = 0; i < NW; i++) cfg_rd_dest[5*i +: 5] = mem_dest[resp_rca][i];
        @(posedge clk);
        #1;
        cfg_rd_src  = SRC_W'($urandom);
        cfg_rd_dest = DEST_W'($urandom);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cfg_rd_en && !rst) pulses++;
    end
  end

  // Monitor: every presented entry must equal the queue head; pop on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_entry", {22'd0, out_last, out_is_dest, out_port_idx, out_reg_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q[0];
          chk("entry", {22'd0, out_last, out_is_dest, out_port_idx, out_reg_addr},
              {22'd0, e.last, e.is_dest, 3'(e.idx), e.addr});
          if (out_ready) begin
            void'(exp_q.pop_front());
            pop_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic randomize_mem();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NR; i++) mem_src[r][i] = 5'($urandom);
      for (int i = 0; i < NW; i++) mem_dest[r][i] = 5'($urandom);
    end
  endtask

  task automatic push_expected(input int sel);
    exp_t e;
    for (int k = 0; k < NE; k++) begin
      e.is_dest = (k >= NR);
      e.idx     = e.is_dest ? k - NR : k;
      e.addr    = e.is_dest ? mem_dest[sel][k-NR] : mem_src[sel][k];
      e.last    = (k == NE - 1);
      exp_q.push_back(e);
    end
  endtask

  // Presents a request and returns 1 ns after the accepting edge.
  task automatic accept_req(input int sel, input bit hold);
    int t;
    @(posedge clk);
    #1;
    req_valid   = 1'b1;
    req_rca_sel = 2'(sel);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready && t < 10);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    push_expected(sel);
    pop_cnt = 0;
    accepts++;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic check_latency(input int sel);
    @(negedge clk);
    chk("fetch_rd_en", {29'd0, cfg_rd_en, cfg_rd_rca}, {29'd1, 2'(sel)});
    chk("fetch_no_valid", {31'd0, out_valid}, 32'd0);
    chk("fetch_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("capture_state", {30'd0, cfg_rd_en, out_valid}, 32'd0);
    @(negedge clk);
    chk("first_valid_3cyc", {31'd0, out_valid}, 32'd1);
    #1;
  endtask

  // mode 0: ready always; 1: random ready; 2: stall 4 cycles on entry 3.
  task automatic drain(input int mode, input bit hold);
    int stall = 0;
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (pop_cnt == 3 && stall < 4) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      if (hold && exp_q.size() <= 1) req_valid = 1'b0;
      @(negedge clk);
      if (hold && req_valid) chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
      #1;
    end
    chk("drain_remaining", exp_q.size(), 32'd0);
    @(negedge clk);
    chk("idle_after_last", {30'd0, out_valid, req_ready}, 32'd1);
    out_ready = 1'b1;
  endtask

  task automatic wait_pops(input int n);
    int t = 0;
    while (pop_cnt < n && t < 50) begin
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      t++;
    end
    chk("reach_entry", pop_cnt, n);
  endtask

  initial begin
    int sel;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_rca_sel = '0;
    out_ready   = 1'b1;
    flush       = 1'b0;
    randomize_mem();
    for (int i = 0; i < NR; i++) mem_src[2][i] = 5'(i + 1);
    mem_dest[2][0] = 5'd10;
    mem_dest[2][1] = 5'd11;
    #1;
    chk("reset_outputs", {20'd0, cfg_rd_en, cfg_rd_rca, out_valid, out_reg_addr, out_is_dest, out_port_idx, out_last},
        32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Known map on RCA 2, ready held high.
    accept_req(2, 1'b0);
    check_latency(2);
    drain(0, 1'b0);

    // Backpressure on entry 3.
    accept_req(2, 1'b0);
    check_latency(2);
    drain(2, 1'b0);

    // Flush while entry 2 is presented, then a complete re-read.
    accept_req(2, 1'b0);
    check_latency(2);
    wait_pops(2);
    @(posedge clk);
    #1;
    flush     = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_to_idle", {30'd0, out_valid, req_ready}, 32'd1);
    out_ready = 1'b1;
    accept_req(2, 1'b0);
    check_latency(2);
    drain(0, 1'b0);

    // Request held high throughout the readback.
    accept_req(1, 1'b1);
    check_latency(1);
    drain(0, 1'b1);
    chk("one_rd_pulse_per_req", pulses, accepts);

    // Reset while capturing.
    accept_req(3, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("reset_in_capture", {20'd0, cfg_rd_en, cfg_rd_rca, out_valid, out_reg_addr, out_is_dest, out_port_idx, out_last},
        32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_release", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("no_entries_after_reset", {31'd0, out_valid}, 32'd0);

    // Flush coincident with the last handshake.
    accept_req(0, 1'b0);
    check_latency(0);
    wait_pops(NE - 1);
    @(posedge clk);
    #1;
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("last_consumed", exp_q.size(), 32'd0);
    repeat (4) @(negedge clk);
    chk("no_extra_after_flush", {30'd0, out_valid, req_ready}, 32'd1);

    // Randomized readbacks with random backpressure.
    for (int n = 0; n < 12; n++) begin
      randomize_mem();
      sel = int'($urandom_range(0, 3));
      accept_req(sel, 1'b0);
      check_latency(sel);
      drain(1, 1'b0);
    end
    chk("rd_pulse_total", pulses, accepts);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
